// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg
//  Shared definitions for the data-memory responder:
//   - access-size encodings (SIZE_B / SIZE_H / SIZE_W, SIZE_X is illegal)
//   - responder FSM state type (IDLE / RD / RESP)
//   - be_gen(size, off): byte-enable mask for a store of the given size at
//     byte offset off within the 32-bit word
//   - lane_gen(size, wdata): store data replicated across the byte lanes so
//     the enabled lanes always carry the operand
package riscv_mem_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_X = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic [3:0] be_gen(input logic [1:0] size,
                                        input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SIZE_B:  be = 4'b0001 << off;
      SIZE_H:  be = 4'b0011 << off;
      SIZE_W:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_gen(input logic [1:0]  size,
                                           input logic [31:0] wdata);
    logic [31:0] lane;
    case (size)
      SIZE_B:  lane = {4{wdata[7:0]}};
      SIZE_H:  lane = {2{wdata[15:0]}};
      default: lane = wdata;
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram
//  Single-port synchronous word RAM, DEPTH_WORDS x 32, with per-byte write
//  enables and a registered read (data appears the cycle after en).
//  Ports:
//   clk    in   clock, rising edge
//   en     in   access enable; read data register updates only when set
//   we     in   4 byte write enables (lane i = bits [8i+7:8i])
//   addr   in   word address
//   wdata  in   write data (already lane-replicated by the caller)
//   rdata  out  registered read data (old contents on a write cycle)
module dmem_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder
//  Far-side data-memory responder for the pipeline's memory stage. Accepts
//  one load/store at a time, applies stores to a byte-enabled word RAM,
//  reads and extends loads, and returns exactly one response per request.
//
//  Handshake: a transfer happens on a rising edge where valid & ready are
//  both high; the sender holds valid and its payload stable until that edge,
//  and the responder holds resp_valid/resp_rdata/resp_err stable until
//  resp_ready is seen with resp_valid.
//
//  Ports:
//   clk, rst       clock and synchronous active-high reset
//   req_valid/req_ready  request handshake (req_ready is high only in IDLE)
//   req_we         1 = store, 0 = load
//   req_size       0 byte, 1 half, 2 word, 3 illegal
//   req_unsigned   load zero-extend when set
//   req_addr       byte address
//   req_wdata      store operand in the low bits
//   resp_valid/resp_ready response handshake
//   resp_rdata     load result, 0 for stores and errors
//   resp_err       misaligned, illegal size or out-of-range address
//   dbg_state      current FSM state
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output state_e      dbg_state
);

  state_e      state, state_next;
  logic        resp_valid_next;
  logic [31:0] rdata_next;
  logic        err_next;

  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [1:0]  lat_off;
  logic        accept;

  logic        req_err;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  // req_ready comes straight from the state register, so resp_ready can
  // never reach it combinationally.
  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign dbg_state = state;

  always_comb begin
    req_err = 1'b0;
    if (req_size == SIZE_X)                           req_err = 1'b1;
    if (req_size == SIZE_H && req_addr[0])            req_err = 1'b1;
    if (req_size == SIZE_W && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if (req_addr[31:AW+2] != '0)                      req_err = 1'b1;
  end

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (req_addr[AW+1:2]),
    .wdata (lane_gen(req_size, req_wdata)),
    .rdata (ram_rdata)
  );

  // Bring the addressed lane down to bit 0, then truncate and extend.
  always_comb begin
    shifted  = ram_rdata >> {lat_off, 3'b000};
    load_ext = shifted;
    case (lat_size)
      SIZE_B:  load_ext = lat_unsigned ? {24'h0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_H:  load_ext = lat_unsigned ? {16'h0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_size     <= SIZE_B;
      lat_unsigned <= 1'b0;
      lat_off      <= 2'b00;
    end else if (accept) begin
      lat_size     <= req_size;
      lat_unsigned <= req_unsigned;
      lat_off      <= req_addr[1:0];
    end
  end

  always_comb begin
    state_next      = state;
    resp_valid_next = resp_valid;
    rdata_next      = resp_rdata;
    err_next        = resp_err;
    ram_en          = 1'b0;
    ram_we          = 4'b0000;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err) begin
            // Errors bypass the RAM entirely so nothing can be modified.
            state_next      = RESP;
            resp_valid_next = 1'b1;
            rdata_next      = 32'h0;
            err_next        = 1'b1;
          end else if (req_we) begin
            ram_en          = 1'b1;
            ram_we          = be_gen(req_size, req_addr[1:0]);
            state_next      = RESP;
            resp_valid_next = 1'b1;
            rdata_next      = 32'h0;
            err_next        = 1'b0;
          end else begin
            ram_en     = 1'b1;
            state_next = RD;
          end
        end
      end
      RD: begin
        state_next      = RESP;
        resp_valid_next = 1'b1;
        rdata_next      = load_ext;
        err_next        = 1'b0;
      end
      RESP: begin
        if (resp_ready) begin
          state_next      = IDLE;
          resp_valid_next = 1'b0;
        end
      end
      default: begin
        state_next      = IDLE;
        resp_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_next;
      resp_valid <= resp_valid_next;
      resp_rdata <= rdata_next;
      resp_err   <= err_next;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  import riscv_mem_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  state_e      dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];
  logic        err_q[$];

  data_mem_responder #(.DEPTH_WORDS(1024), .AW(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Drives one request, waits for its response (bounded), checks latency and
  // payload against the scoreboard, optionally stalls the consumer for `hold`
  // cycles, then either consumes the response or resets the DUT.
  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int hold, input bit do_rst);
    int          lat;
    bit          got;
    logic [31:0] e_rdata;
    logic        e_err;
    logic [31:0] held;
    exp_q.push_back(exp_rdata);
    err_q.push_back(exp_err);
    @(negedge clk);
    check({tag, ".req_ready"}, {31'h0, req_ready}, 32'h1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (resp_valid) got = 1'b1;
    end
    e_rdata = exp_q.pop_front();
    e_err   = err_q.pop_front();
    check({tag, ".resp_seen"}, {31'h0, got}, 32'h1);
    if (got) begin
      check({tag, ".latency"}, lat, (we || exp_err) ? 32'd1 : 32'd2);
      check({tag, ".rdata"}, resp_rdata, e_rdata);
      check({tag, ".err"}, {31'h0, resp_err}, {31'h0, e_err});
    end
    held = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold_valid"}, {31'h0, resp_valid}, 32'h1);
      check({tag, ".hold_rdata"}, resp_rdata, held);
      check({tag, ".hold_req_ready"}, {31'h0, req_ready}, 32'h0);
    end
    if (do_rst) begin
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check({tag, ".rst_valid"}, {31'h0, resp_valid}, 32'h0);
      check({tag, ".rst_req_ready"}, {31'h0, req_ready}, 32'h1);
      check({tag, ".rst_state"}, {30'h0, dbg_state}, 32'h0);
      check({tag, ".rst_rdata"}, resp_rdata, 32'h0);
    end else begin
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      @(negedge clk);
      check({tag, ".drain_valid"}, {31'h0, resp_valid}, 32'h0);
    end
  endtask

  initial begin
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = SIZE_W;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    resp_ready   = 1'b0;

    // 1. reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.req_ready",  {31'h0, req_ready},  32'h1);
    check("reset.resp_valid", {31'h0, resp_valid}, 32'h0);
    check("reset.resp_rdata", resp_rdata,          32'h0);
    check("reset.resp_err",   {31'h0, resp_err},   32'h0);
    check("reset.state",      {30'h0, dbg_state},  32'h0);
    rst = 1'b0;

    // 2. word store / load
    do_req("sw10",  1, SIZE_W, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 0, 0);
    do_req("lw10",  0, SIZE_W, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 0, 0);

    // 3. byte store into a known word, signed/unsigned byte loads
    do_req("sw10b", 1, SIZE_W, 0, 32'h10, 32'h11223344, 32'h0,        0, 0, 0);
    do_req("sb13",  1, SIZE_B, 0, 32'h13, 32'h00000080, 32'h0,        0, 0, 0);
    do_req("lw10c", 0, SIZE_W, 0, 32'h10, 32'h0,        32'h80223344, 0, 0, 0);
    do_req("lb13",  0, SIZE_B, 0, 32'h13, 32'h0,        32'hFFFFFF80, 0, 0, 0);
    do_req("lbu13", 0, SIZE_B, 1, 32'h13, 32'h0,        32'h00000080, 0, 0, 0);
    do_req("lb11",  0, SIZE_B, 0, 32'h11, 32'h0,        32'h00000033, 0, 0, 0);
    do_req("lh10",  0, SIZE_H, 0, 32'h10, 32'h0,        32'h00003344, 0, 0, 0);

    // 4. half store at the upper half, signed/unsigned half loads
    do_req("sh12",  1, SIZE_H, 0, 32'h12, 32'h0000A5A5, 32'h0,        0, 0, 0);
    do_req("lh12",  0, SIZE_H, 0, 32'h12, 32'h0,        32'hFFFFA5A5, 0, 0, 0);
    do_req("lhu12", 0, SIZE_H, 1, 32'h12, 32'h0,        32'h0000A5A5, 0, 0, 0);
    do_req("lw10d", 0, SIZE_W, 0, 32'h10, 32'h0,        32'hA5A53344, 0, 0, 0);
    do_req("lwu10", 0, SIZE_W, 1, 32'h10, 32'h0,        32'hA5A53344, 0, 0, 0);

    // 5. errors leave memory untouched; top word and aliasing boundary
    do_req("sw0",   1, SIZE_W, 0, 32'h0,    32'h01020304, 32'h0, 0, 0, 0);
    do_req("swffc", 1, SIZE_W, 0, 32'hFFC,  32'hCAFEF00D, 32'h0, 0, 0, 0);
    do_req("lw11",  0, SIZE_W, 0, 32'h11,   32'h0,        32'h0, 1, 0, 0);
    do_req("sh13",  1, SIZE_H, 0, 32'h13,   32'h0000FFFF, 32'h0, 1, 0, 0);
    do_req("sw12",  1, SIZE_W, 0, 32'h12,   32'hFFFFFFFF, 32'h0, 1, 0, 0);
    do_req("sz3",   1, SIZE_X, 0, 32'h10,   32'h12345678, 32'h0, 1, 0, 0);
    do_req("lsz3",  0, SIZE_X, 0, 32'h10,   32'h0,        32'h0, 1, 0, 0);
    do_req("lw1000",0, SIZE_W, 0, 32'h1000, 32'h0,        32'h0, 1, 0, 0);
    do_req("sw1000",1, SIZE_W, 0, 32'h1000, 32'hFFFFFFFF, 32'h0, 1, 0, 0);
    do_req("lw10e", 0, SIZE_W, 0, 32'h10,   32'h0, 32'hA5A53344, 0, 0, 0);
    do_req("lw0",   0, SIZE_W, 0, 32'h0,    32'h0, 32'h01020304, 0, 0, 0);
    do_req("lwffc", 0, SIZE_W, 0, 32'hFFC,  32'h0, 32'hCAFEF00D, 0, 0, 0);

    // 6. backpressure, then reset while a response is pending
    do_req("bp",    0, SIZE_W, 0, 32'h10, 32'h0, 32'hA5A53344, 0, 5, 0);
    do_req("rstp",  0, SIZE_B, 0, 32'h13, 32'h0, 32'hFFFFFFA5, 0, 2, 1);
    do_req("post",  0, SIZE_H, 1, 32'h10, 32'h0, 32'h00003344, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
